if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, an internal

---
 rtl/if_stage_if.sv | 35 +++
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if
//   Bundles the fetch-stage control, instruction-memory load port and IF/ID
//   outputs into one port.
//   master: drives stall/pcsrc/jump/branch_imm/jump_addr and the imem load port;
//           observes pc and the IF/ID register.
//   slave : the fetch stage itself.
interface if_stage_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic              pcsrc;
    logic              jump;
    logic [15:0]       branch_imm;
    logic [25:0]       jump_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       pc;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc4;
    logic              ifid_valid;
    logic [31:0]       fetch_count;

    modport master (
        output stall, pcsrc, jump, branch_imm, jump_addr,
        output imem_we, imem_addr, imem_wdata,
        input  pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );

    modport slave (
        input  stall, pcsrc, jump, branch_imm, jump_addr,
        input  imem_we, imem_addr, imem_wdata,
        output pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC, a
//   word-addressed instruction memory (2**ADDR_W words) and the IF/ID register.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous active-high reset (memory contents are kept)
//     bus    if_stage_if.slave: stall/pcsrc/jump redirect controls from ID,
//            imem load port, pc and IF/ID outputs plus a fetch counter.
module if_stage #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic       clock,
    input  logic       reset,
    if_stage_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] imem [DEPTH];

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       pc_plus4;
    logic [31:0]       branch_off;
    logic [31:0]       fetch_word;

    // Loading is independent of reset and stall so software can fill memory
    // while the pipeline is held. The non-blocking write means a fetch of the
    // same index in that cycle still sees the old word.
    always_ff @(posedge clock) begin
        if (bus.imem_we) begin
            imem[bus.imem_addr] <= bus.imem_wdata;
        end
    end

    // Upper PC bits are ignored, so fetches wrap modulo the memory depth.
    assign fetch_idx  = pc_q[ADDR_W+1:2];
    assign fetch_word = imem[fetch_idx];
    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (bus.stall) begin
            // hold everything; redirects wait until the hazard clears
        end else if (bus.jump) begin
            // jump wins over a simultaneous pcsrc
            pc_d    = {pc4_q[31:28], bus.jump_addr, 2'b00};
            instr_d = 32'h0;
            valid_d = 1'b0;
            pc4_d   = pc_plus4;
        end else if (bus.pcsrc) begin
            // squash the single wrong-path instruction fetched this cycle
            pc_d    = pc4_q + branch_off;
            instr_d = 32'h0;
            valid_d = 1'b0;
            pc4_d   = pc_plus4;
        end else begin
            pc_d    = pc_plus4;
            instr_d = fetch_word;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.ifid_instr  = instr_q;
    assign bus.ifid_pc4    = pc4_q;
    assign bus.ifid_valid  = valid_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage
//   Randomized and directed stimulus for if_stage. Each issued cycle pushes the
//   reference model's expected post-edge outputs into a queue; an independent
//   monitor pops and compares after every rising edge.
module tb_if_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;

    if_stage_if #(.ADDR_W(8)) bus ();

    if_stage #(.ADDR_W(8), .PC_RESET(32'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    // One rising edge of the fetch stage, straight from the behavioural rules.
    task automatic model_edge(input logic st, input logic ps, input logic jp,
                              input logic [15:0] imm, input logic [25:0] ja,
                              input logic we, input logic [7:0] wa, input logic [31:0] wd);
        logic [31:0] word;
        logic [31:0] off;
        exp_t e;
        word = m_mem[(m_pc / 4) % 256];
        off  = {{16{imm[15]}}, imm};
        if (!st) begin
            if (jp) begin
                m_pc4   = m_pc + 4;
                m_pc    = {e.pc4[31:28] & 4'h0 | m_pc4_hi(m_pc4, m_pc), ja, 2'b00};
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else if (ps) begin
                logic [31:0] old_pc4;
                old_pc4 = m_pc4;
                m_pc4   = m_pc + 4;
                m_pc    = old_pc4 + off * 4;
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else begin
                m_instr = word;
                m_pc    = m_pc + 4;
                m_pc4   = m_pc;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 1;
            end
        end
        if (we) m_mem[wa] = wd;
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    // Jump keeps the top nibble of the IF/ID PC+4 held before the edge; the
    // caller has already overwritten m_pc4, so rebuild the old value here.
    logic [31:0] jump_base;
    function automatic logic [3:0] m_pc4_hi(input logic [31:0] new_pc4, input logic [31:0] cur_pc);
        if (new_pc4 == cur_pc + 4) return jump_base[31:28];
        return jump_base[31:28];
    endfunction

    task automatic step(input logic st, input logic ps, input logic jp,
                        input logic [15:0] imm, input logic [25:0] ja,
                        input logic we, input logic [7:0] wa, input logic [31:0] wd);
        @(negedge clock);
        bus.stall = st; bus.pcsrc = ps; bus.jump = jp;
        bus.branch_imm = imm; bus.jump_addr = ja;
        bus.imem_we = we; bus.imem_addr = wa; bus.imem_wdata = wd;
        jump_base = m_pc4;
        model_edge(st, ps, jp, imm, ja, we, wa, wd);
        @(posedge clock);
        #2;
    endtask

    task automatic free_step();
        step(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_pc"},    bus.pc,                 32'h0);
        chk({tag, "_instr"}, bus.ifid_instr,         32'h0);
        chk({tag, "_pc4"},   bus.ifid_pc4,           32'h0);
        chk({tag, "_valid"}, 32'(bus.ifid_valid),    32'h0);
        chk({tag, "_count"}, bus.fetch_count,        32'h0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clock);
        bus.stall = 1'b1; bus.pcsrc = 1'b0; bus.jump = 1'b0; bus.imem_we = 1'b0;
        #2 reset = 1'b1;
        #1 check_cleared(tag);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pc",    bus.pc,              e.pc);
                chk("sb_instr", bus.ifid_instr,      e.instr);
                chk("sb_pc4",   bus.ifid_pc4,        e.pc4);
                chk("sb_valid", 32'(bus.ifid_valid), 32'(e.valid));
                chk("sb_count", bus.fetch_count,     e.cnt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old5;
        bus.stall = 1'b1; bus.pcsrc = 1'b0; bus.jump = 1'b0;
        bus.branch_imm = 16'h0; bus.jump_addr = 26'h0;
        bus.imem_we = 1'b0; bus.imem_addr = 8'h0; bus.imem_wdata = 32'h0;
        jump_base = 32'h0;
        model_reset();

        // fill memory while held in reset
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            case (i)
                0: w = 32'h11;
                1: w = 32'h22;
                2: w = 32'h33;
                3: w = 32'h44;
                default: w = $urandom;
            endcase
            @(negedge clock);
            bus.imem_we = 1'b1; bus.imem_addr = 8'(i); bus.imem_wdata = w;
            m_mem[i] = w;
        end
        @(negedge clock);
        bus.imem_we = 1'b0;
        check_cleared("reset");
        reset = 1'b0;

        // free run, then stall at pc=8
        free_step();
        chk("run_pc1", bus.pc, 32'h4);
        chk("run_instr1", bus.ifid_instr, 32'h11);
        free_step();
        chk("run_pc2", bus.pc, 32'h8);
        chk("run_instr2", bus.ifid_instr, 32'h22);
        step(1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 8'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 16'h5, 26'h7, 1'b0, 8'h0, 32'h0);
        chk("stall_pc", bus.pc, 32'h8);
        chk("stall_instr", bus.ifid_instr, 32'h22);
        chk("stall_count", bus.fetch_count, 32'd2);
        free_step();
        chk("resume_instr", bus.ifid_instr, 32'h33);
        chk("resume_count", bus.fetch_count, 32'd3);
        chk("resume_pc", bus.pc, 32'd12);

        // branch back from ifid_pc4=8 with imm=-2
        do_reset("midrun1");
        free_step();
        free_step();
        chk("pre_br_pc4", bus.ifid_pc4, 32'h8);
        step(1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0, 1'b0, 8'h0, 32'h0);
        chk("br_pc", bus.pc, 32'h0);
        chk("br_instr", bus.ifid_instr, 32'h0);
        chk("br_valid", 32'(bus.ifid_valid), 32'h0);
        free_step();
        chk("br_refetch", bus.ifid_instr, 32'h11);
        step(1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0, 1'b0, 8'h0, 32'h0);
        chk("br_stalled_pc", bus.pc, 32'h4);

        // reach a high PC, then jump keeps the top nibble; jump beats pcsrc
        free_step();
        step(1'b0, 1'b1, 1'b0, 16'h8000, 26'h0, 1'b0, 8'h0, 32'h0);
        chk("far_br_pc", bus.pc, 32'hFFFE_0008);
        free_step();
        chk("far_instr", bus.ifid_instr, 32'h33);
        step(1'b0, 1'b0, 1'b1, 16'h0, 26'h10, 1'b0, 8'h0, 32'h0);
        chk("jump_pc", bus.pc, 32'hF000_0040);
        chk("jump_valid", 32'(bus.ifid_valid), 32'h0);
        free_step();
        step(1'b0, 1'b1, 1'b1, 16'h1, 26'h20, 1'b0, 8'h0, 32'h0);
        chk("jump_wins_pc", bus.pc, 32'hF000_0080);

        // index wrap at pc=0x400 and PC wrap at 0xFFFFFFFC
        do_reset("midrun2");
        free_step();
        free_step();
        step(1'b0, 1'b1, 1'b0, 16'h00FE, 26'h0, 1'b0, 8'h0, 32'h0);
        chk("wrap_pc", bus.pc, 32'h400);
        free_step();
        chk("wrap_instr", bus.ifid_instr, 32'h11);
        step(1'b0, 1'b1, 1'b0, 16'hFEFE, 26'h0, 1'b0, 8'h0, 32'h0);
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        free_step();
        chk("pc_wrap", bus.pc, 32'h0);
        chk("pc_wrap_instr", bus.ifid_instr, m_mem[255]);

        // write and fetch the same index in one cycle
        do_reset("midrun3");
        for (int i = 0; i < 5; i++) free_step();
        old5 = m_mem[5];
        step(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b1, 8'd5, 32'hDEAD_BEEF);
        chk("wr_old_word", bus.ifid_instr, old5);
        do_reset("midrun4");
        for (int i = 0; i < 6; i++) free_step();
        chk("wr_new_word", bus.ifid_instr, 32'hDEAD_BEEF);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic st, ps, jp, we;
            st = ($urandom_range(0, 99) < 20);
            ps = ($urandom_range(0, 99) < 15);
            jp = ($urandom_range(0, 99) < 8);
            we = ($urandom_range(0, 99) < 20);
            step(st, ps, jp, 16'($urandom), 26'($urandom), we, 8'($urandom), $urandom);
        end

        @(negedge clock);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
